// File: rtl/laby4_poda_pkg.sv
// laby4_poda_pkg: shared truth-table constants, default counter width and
// the table lookup helper for the laby4_poda function unit.
package laby4_poda_pkg;

    // Truth tables indexed by {b,c}
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    localparam int unsigned CNT_W_DEF = 8;

    function automatic logic tt_lookup(input logic [3:0] tt, input logic b, input logic c);
        return tt[{b, c}];
    endfunction

endpackage

// File: rtl/laby4_poda_sync.sv
// laby4_poda_sync: 1-bit two-flop synchronizer, async active-low reset to 0.
module laby4_poda_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;

    // Two back-to-back flops; meta_q may go metastable, o_q is the safe copy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= 1'b0;
            o_q    <= 1'b0;
        end else begin
            meta_q <= i_d;
            o_q    <= meta_q;
        end
    end

endmodule

// File: rtl/laby4_poda.sv
// laby4_poda: programmable 2-input Boolean function unit. y = tt[{b,c}],
// registered, with a toggle pulse and a saturating high-cycle counter.
// Optional macro LABY4_PODA_SYNC_EN puts a 2-flop synchronizer on b and c.
module laby4_poda
    import laby4_poda_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter logic [3:0]  TT_RST = TT_XOR
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_b,
    input  logic             i_c,
    input  logic             i_cfg_we,
    input  logic [3:0]       i_cfg_tt,
    input  logic             i_cnt_clr,
    output logic             o_y,
    output logic             o_toggle,
    output logic [3:0]       o_tt,
    output logic [CNT_W-1:0] o_high_cnt
);

    logic       b_eval;
    logic       c_eval;
    logic [3:0] tt_q;
    logic       y_d;

`ifdef LABY4_PODA_SYNC_EN
    laby4_poda_sync u_sync_b (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_b),
        .o_q     (b_eval)
    );

    laby4_poda_sync u_sync_c (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_c),
        .o_q     (c_eval)
    );
`else
    assign b_eval = i_b;
    assign c_eval = i_c;
`endif

    // Lookup uses the table value before any write at this edge
    assign y_d  = tt_lookup(tt_q, b_eval, c_eval);
    assign o_tt = tt_q;

    // Truth-table register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tt_q <= TT_RST;
        end else if (i_cfg_we) begin
            tt_q <= i_cfg_tt;
        end
    end

    // Registered result and change pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_y      <= 1'b0;
            o_toggle <= 1'b0;
        end else begin
            o_y      <= y_d;
            o_toggle <= (y_d != o_y);
        end
    end

    // Saturating count of cycles where the registered y is high; clear wins
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_high_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_high_cnt <= '0;
        end else if (o_y && (o_high_cnt != {CNT_W{1'b1}})) begin
            o_high_cnt <= o_high_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_laby4_poda.sv
// tb_laby4_poda: directed, self-checking bench for laby4_poda. A reference
// model predicts each edge's outputs into a scoreboard queue that is popped
// and compared just after the edge.
`timescale 1ns/1ps
module tb_laby4_poda;

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
    localparam logic [3:0] T_AND = 4'b1000;
    localparam logic [3:0] T_XOR = 4'b0110;
`ifdef LABY4_PODA_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic             y;
        logic             tog;
        logic [3:0]       tt;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             b, c, cfg_we, cnt_clr;
    logic [3:0]       cfg_tt;
    logic             y, toggle;
    logic [3:0]       tt;
    logic [CNT_W-1:0] high_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic             m_y, m_tog;
    logic [3:0]       m_tt;
    logic [CNT_W-1:0] m_cnt;
    logic [1:0]       in_q[$];
    exp_t             exp_q[$];

    laby4_poda #(.CNT_W(CNT_W), .TT_RST(4'b0110)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_b        (b),
        .i_c        (c),
        .i_cfg_we   (cfg_we),
        .i_cfg_tt   (cfg_tt),
        .i_cnt_clr  (cnt_clr),
        .o_y        (y),
        .o_toggle   (toggle),
        .o_tt       (tt),
        .o_high_cnt (high_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_y = 1'b0; m_tog = 1'b0; m_tt = T_XOR; m_cnt = '0;
        in_q.delete();
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) in_q.push_back(2'b00);
    endtask

    // One clock: drive inputs, predict at the edge, compare 1 ns later
    task automatic step(input logic sb, input logic sc, input logic swe,
                        input logic [3:0] stt, input logic sclr);
        logic [1:0] idx;
        logic       ny;
        exp_t       e;
        b = sb; c = sc; cfg_we = swe; cfg_tt = stt; cnt_clr = sclr;
        @(posedge clk);
        in_q.push_back({sb, sc});
        idx = in_q.pop_front();
        ny  = m_tt[idx];
        m_tog = (ny != m_y);
        if (sclr) m_cnt = '0;
        else if (m_y && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
        m_y = ny;
        if (swe) m_tt = stt;
        exp_q.push_back('{y: m_y, tog: m_tog, tt: m_tt, cnt: m_cnt});
        #1;
        e = exp_q.pop_front();
        chk("y", {31'd0, y}, {31'd0, e.y});
        chk("toggle", {31'd0, toggle}, {31'd0, e.tog});
        chk("tt", {28'd0, tt}, {28'd0, e.tt});
        chk("cnt", {24'd0, high_cnt}, {24'd0, e.cnt});
    endtask

    initial begin
        int n;
        rst_n = 1'b0; b = 0; c = 0; cfg_we = 0; cfg_tt = '0; cnt_clr = 0;
        model_reset();
        #12;
        chk("rst_y", {31'd0, y}, 32'd0);
        chk("rst_toggle", {31'd0, toggle}, 32'd0);
        chk("rst_tt", {28'd0, tt}, 32'h6);
        chk("rst_cnt", {24'd0, high_cnt}, 32'd0);
        #5 rst_n = 1'b1;

        // XOR sweep 00,01,10,11 then settle
        step(0, 0, 0, 4'h0, 0);
        step(0, 1, 0, 4'h0, 0);
        step(1, 0, 0, 4'h0, 0);
        step(1, 1, 0, 4'h0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 4'h0, 0);
        chk("xor11_y", {31'd0, y}, 32'd0);

        // AND written on the same edge as b=c=1: old table first
        step(1, 1, 1, T_AND, 0);
        chk("cfgwr_old_y", {31'd0, y}, 32'd0);
        chk("cfgwr_tt", {28'd0, tt}, 32'h8);
        step(1, 1, 0, 4'h0, 0);
        chk("cfgwr_new_y", {31'd0, y}, 32'd1);

        // Back to XOR, hold b=1 c=0 to saturate the counter
        step(1, 0, 1, T_XOR, 0);
        for (int i = 0; i < 300; i++) step(1, 0, 0, 4'h0, 0);
        chk("sat_cnt", {24'd0, high_cnt}, 32'd255);
        step(1, 0, 0, 4'h0, 0);
        chk("sat_hold", {24'd0, high_cnt}, 32'd255);

        // Clear while y=1, then resume counting
        step(1, 0, 0, 4'h0, 1);
        chk("clr_cnt0", {24'd0, high_cnt}, 32'd0);
        step(1, 0, 0, 4'h0, 0);
        chk("clr_cnt1", {24'd0, high_cnt}, 32'd1);
        step(1, 0, 0, 4'h0, 0);
        chk("clr_cnt2", {24'd0, high_cnt}, 32'd2);

        // Reach y=1, tt=AND, cnt=37 then reset asynchronously mid-cycle
        step(1, 1, 1, T_AND, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 4'h0, 0);
        step(1, 1, 0, 4'h0, 1);
        for (int i = 0; i < 37; i++) step(1, 1, 0, 4'h0, 0);
        chk("pre_rst_cnt", {24'd0, high_cnt}, 32'd37);
        chk("pre_rst_y", {31'd0, y}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_y", {31'd0, y}, 32'd0);
        chk("arst_toggle", {31'd0, toggle}, 32'd0);
        chk("arst_tt", {28'd0, tt}, 32'h6);
        chk("arst_cnt", {24'd0, high_cnt}, 32'd0);
        model_reset();
        #2 rst_n = 1'b1;

        // Latency: b 0 -> 1 with c=0 under XOR
        for (int i = 0; i < 4; i++) step(0, 0, 0, 4'h0, 0);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1, 0, 0, 4'h0, 0);
            if (y === 1'b1 && n == 0) n = i;
        end
        chk("latency", n, LAT);

        // Random mixed traffic against the model
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                 4'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish by 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
